// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button event unit: event word layout and edge encoding.
package btn_evt_pkg;

    // Edge type carried in the event word MSB
    localparam logic EDGE_PRESS   = 1'b1;
    localparam logic EDGE_RELEASE = 1'b0;

    // Channel index occupies the low bits of the event word
    localparam int EVT_CHAN_LSB = 0;

    // Event word width: channel index bits plus one edge bit
    function automatic int evt_w(input int n_btn);
        return $clog2(n_btn) + 1;
    endfunction

    // Bit position of the edge flag inside the event word
    function automatic int evt_edge_pos(input int n_btn);
        return evt_w(n_btn) - 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, stability counter and edge strobes.
// Optional feature macro: BTN_EVT_RELEASE_EN (enables release strobes).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic state,
    output logic press_stb,
    output logic release_stb
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the raw asynchronous level into the clock domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing cycles; accept the new level and strobe once the count completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            state       <= 1'b0;
            press_stb   <= 1'b0;
            release_stb <= 1'b0;
        end else begin
            press_stb   <= 1'b0;
            release_stb <= 1'b0;
            if (sync2 == state) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt       <= '0;
                state     <= ~state;
                press_stb <= ~state;
`ifdef BTN_EVT_RELEASE_EN
                release_stb <= state;
`else
                release_stb <= 1'b0;
`endif
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_event_unit.sv
// Button event unit: per-channel debouncers, pending-bit arbiter and event FIFO.
// Optional feature macro: BTN_EVT_RELEASE_EN (queue release events as well as presses).
module btn_event_unit
    import btn_evt_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_BTN-1:0]              btn,
    output logic [N_BTN-1:0]              btn_state,
    output logic                          evt_valid,
    output logic [evt_w(N_BTN)-1:0]       evt_data,
    input  logic                          evt_pop,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          ovf,
    input  logic                          ovf_clr
);

    localparam int EVT_W = evt_w(N_BTN);
    localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [N_BTN-1:0] press_vec;
    logic [N_BTN-1:0] release_vec;
    logic [N_BTN-1:0] strobe_vec;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] edge_type;
    logic [N_BTN-1:0] push_mask;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    logic [EVT_W-1:0] push_word;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             lost;

    logic [EVT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk        (clk),
            .reset      (reset),
            .btn        (btn[g]),
            .state      (btn_state[g]),
            .press_stb  (press_vec[g]),
            .release_stb(release_vec[g])
        );
    end

    assign strobe_vec = press_vec | release_vec;
    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop     = evt_pop && (count != '0);
    assign do_push    = sel_valid && (!full || evt_pop);
    assign lost       = |(strobe_vec & pending & ~push_mask);
    assign evt_valid  = (count != '0);
    assign evt_count  = count;
    assign evt_data   = evt_valid ? mem[rd_ptr] : '0;

    // Fixed-priority pick of the lowest-index pending channel and its event word
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        push_mask = do_push ? (N_BTN'(1) << sel_idx) : '0;
        push_word = EVT_W'(sel_idx) << EVT_CHAN_LSB;
        push_word[evt_edge_pos(N_BTN)] = edge_type[sel_idx];
    end

    // Latch strobes as pending events; a strobe landing on an unsent event overwrites it and flags the loss
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   <= '0;
            edge_type <= '0;
            ovf       <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (strobe_vec[i]) begin
                    pending[i]   <= 1'b1;
                    edge_type[i] <= press_vec[i] ? EDGE_PRESS : EDGE_RELEASE;
                end else if (push_mask[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            if (lost) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // Event storage; contents are only meaningful where the pointers say so, so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event_unit.sv
// Self-checking bench for btn_event_unit with N_BTN=4, DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
// Expected events are queued when buttons are driven and compared as the unit emits them.
module tb_btn_event_unit;

    logic       clk;
    logic       reset;
    logic [3:0] btn;
    logic [3:0] btn_state;
    logic       evt_valid;
    logic [2:0] evt_data;
    logic       evt_pop;
    logic [2:0] evt_count;
    logic       ovf;
    logic       ovf_clr;

    int checks = 0;
    int errors = 0;
    logic [2:0] sb[$];

    btn_event_unit #(
        .N_BTN(4),
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .btn_state(btn_state),
        .evt_valid(evt_valid),
        .evt_data (evt_data),
        .evt_pop  (evt_pop),
        .evt_count(evt_count),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n cycles, leaving time just after the rising edge
    task automatic waitCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive new button levels and queue the events they should produce
    task automatic applyStimulus(input logic [3:0] val);
        for (int i = 0; i < 4; i++) begin
            if (!btn[i] && val[i]) sb.push_back({1'b1, 2'(i)});
        end
`ifdef BTN_EVT_RELEASE_EN
        for (int i = 0; i < 4; i++) begin
            if (btn[i] && !val[i]) sb.push_back({1'b0, 2'(i)});
        end
`endif
        btn = val;
    endtask

    task automatic waitValid(input int budget);
        int n;
        n = 0;
        while (!evt_valid && n < budget) begin
            waitCycles(1);
            n++;
        end
        checkOutput("evt_valid_wait", {31'd0, evt_valid}, 32'd1);
    endtask

    // Compare the head event with the scoreboard and consume it
    task automatic popAndCheck(input string tag);
        logic [2:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : 3'bxxx;
        checkOutput(tag, {29'd0, evt_data}, {29'd0, exp});
        evt_pop = 1'b1;
        waitCycles(1);
        evt_pop = 1'b0;
    endtask

    task automatic drainAll(input string tag);
        while (sb.size() > 0) begin
            waitValid(30);
            if (!evt_valid) begin
                sb.delete();
                break;
            end
            popAndCheck(tag);
        end
        checkOutput({tag, "_count"}, {29'd0, evt_count}, 32'd0);
        checkOutput({tag, "_valid"}, {31'd0, evt_valid}, 32'd0);
    endtask

    initial begin
        reset   = 1'b0;
        btn     = 4'b0000;
        evt_pop = 1'b0;
        ovf_clr = 1'b0;
        waitCycles(3);
        reset = 1'b1;
        waitCycles(1);

        $display("[TB] reset state");
        checkOutput("rst_state", {28'd0, btn_state}, 32'd0);
        checkOutput("rst_valid", {31'd0, evt_valid}, 32'd0);
        checkOutput("rst_count", {29'd0, evt_count}, 32'd0);
        checkOutput("rst_ovf",   {31'd0, ovf},       32'd0);

        $display("[TB] single press latency");
        applyStimulus(4'b0100);
        waitCycles(7);
        checkOutput("lat_early_valid", {31'd0, evt_valid}, 32'd0);
        waitCycles(1);
        checkOutput("lat_valid", {31'd0, evt_valid}, 32'd1);
        checkOutput("lat_state", {28'd0, btn_state}, 32'h4);
        popAndCheck("lat_data");
        checkOutput("lat_pop_count", {29'd0, evt_count}, 32'd0);

        $display("[TB] glitch rejection");
        applyStimulus(4'b0110);
        waitCycles(3);
        btn = 4'b0100;
        sb.pop_back();
        waitCycles(12);
        checkOutput("glitch_state", {28'd0, btn_state}, 32'h4);
        checkOutput("glitch_count", {29'd0, evt_count}, 32'd0);

        $display("[TB] simultaneous presses");
        applyStimulus(4'b1101);
        waitCycles(8);
        checkOutput("simul_count1", {29'd0, evt_count}, 32'd1);
        waitCycles(1);
        checkOutput("simul_count2", {29'd0, evt_count}, 32'd2);
        popAndCheck("simul_first");
        popAndCheck("simul_second");
        applyStimulus(4'b0000);
        waitCycles(12);
        drainAll("simul_release");

        $display("[TB] press then release");
        applyStimulus(4'b0010);
        waitCycles(10);
        applyStimulus(4'b0000);
        waitCycles(12);
        drainAll("pr_rel");

        $display("[TB] overflow");
        applyStimulus(4'b1111);
        waitCycles(14);
        checkOutput("ovf_full_count", {29'd0, evt_count}, 32'd4);
        checkOutput("ovf_not_yet", {31'd0, ovf}, 32'd0);
        btn[0] = 1'b0;
        waitCycles(9);
        btn[0] = 1'b1;
        waitCycles(9);
        btn[0] = 1'b0;
        waitCycles(9);
        btn[0] = 1'b1;
        waitCycles(9);
        checkOutput("ovf_count_held", {29'd0, evt_count}, 32'd4);
        checkOutput("ovf_set", {31'd0, ovf}, 32'd1);
        popAndCheck("ovf_pop_head");
        sb.push_back(3'b100);
        checkOutput("ovf_pop_push_count", {29'd0, evt_count}, 32'd4);
        ovf_clr = 1'b1;
        waitCycles(1);
        ovf_clr = 1'b0;
        checkOutput("ovf_clr", {31'd0, ovf}, 32'd0);
        drainAll("ovf_drain");

        $display("[TB] mid-operation reset");
        applyStimulus(4'b0000);
        waitCycles(12);
        drainAll("pre_rst");
        applyStimulus(4'b0111);
        waitCycles(10);
        checkOutput("pre_rst_count", {29'd0, evt_count}, 32'd3);
        applyStimulus(4'b1111);
        waitCycles(4);
        reset = 1'b0;
        #1;
        checkOutput("mrst_state", {28'd0, btn_state}, 32'd0);
        checkOutput("mrst_valid", {31'd0, evt_valid}, 32'd0);
        checkOutput("mrst_count", {29'd0, evt_count}, 32'd0);
        checkOutput("mrst_ovf",   {31'd0, ovf},       32'd0);
        checkOutput("mrst_data",  {29'd0, evt_data},  32'd0);
        waitCycles(1);
        reset = 1'b1;
        sb.delete();
        sb.push_back(3'b100);
        sb.push_back(3'b101);
        sb.push_back(3'b110);
        sb.push_back(3'b111);
        waitCycles(7);
        checkOutput("rerep_early", {31'd0, evt_valid}, 32'd0);
        waitCycles(1);
        checkOutput("rerep_valid", {31'd0, evt_valid}, 32'd1);
        popAndCheck("rerep_first");
        drainAll("rerep");

        applyStimulus(4'b0000);
        waitCycles(12);
        drainAll("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL timeout: observed running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_event_unit.md
BTN_EVENT_UNIT -- requirements
Module: btn_event_unit

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of button channels, range 1..16.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: number of clock cycles an input must be stable before it is accepted; minimum 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: event queue depth; power of two, minimum 2.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low (0 = reset asserted).
REQ-006 SHALL have port btn, input, N_BTN bits: raw, asynchronous button levels; bit i = channel i.
REQ-007 SHALL have port btn_state, output, N_BTN bits: debounced button levels.
REQ-008 SHALL have port evt_valid, output, 1 bit: event queue is non-empty.
REQ-009 SHALL have port evt_data, output, EVT_W bits: head event; MSB = edge (1 press, 0 release); low bits = channel index.
REQ-010 SHALL have port evt_pop, input, 1 bit: consume the head event.
REQ-011 SHALL have port evt_count, output, $clog2(FIFO_DEPTH)+1 bits: number of queued events.
REQ-012 SHALL have port ovf, output, 1 bit: sticky flag; set when an event is lost.
REQ-013 SHALL have port ovf_clr, input, 1 bit: clears ovf.

Function
REQ-014 SHALL pass each btn bit through a 2-flop synchroniser before any other logic uses it.
REQ-015 SHALL give each channel its own counter; the counter clears whenever the synchronised input equals btn_state[i], and btn_state[i] toggles when the input has differed for DEBOUNCE_CYCLES consecutive cycles.
REQ-016 SHALL raise a one-cycle edge strobe on every btn_state toggle: press on 0->1, release on 1->0.
REQ-017 SHALL set channel pending bit and latch the edge type on a strobe; a strobe while already pending overwrites the edge type and sets ovf.
REQ-018 SHALL push at most one event per cycle; lowest-index pending channel wins; its pending bit clears on the push.
REQ-019 SHALL not push while the FIFO is full, except when evt_pop is asserted in the same cycle, in which case both the push and the pop take effect.
REQ-020 SHALL make an isolated press visible on evt_valid and evt_data exactly DEBOUNCE_CYCLES+4 cycles after the raw edge: 2 synchroniser + DEBOUNCE_CYCLES filter + 1 pending + 1 write.
REQ-021 SHALL ignore evt_pop while the queue is empty; evt_data is a don't-care while evt_valid=0.
REQ-022 SHALL wrap pointers modulo FIFO_DEPTH; evt_count ranges 0..FIFO_DEPTH.
REQ-023 SHALL give set priority over clear when ovf_clr and an ovf-setting event occur in the same cycle.
REQ-024 SHALL reject a glitch shorter than DEBOUNCE_CYCLES; no state change and no event result.

Reset
REQ-025 SHALL, while reset=0, force to zero: synchronisers, counters, btn_state, pending bits, FIFO pointers, evt_count, evt_valid, ovf.
REQ-026 SHALL discard in-flight debounce progress and queued events on a mid-operation reset; a button held through reset release produces a press event after the normal latency.

Configuration
REQ-027 SHALL, with BTN_EVT_RELEASE_EN defined, queue both press and release events.
REQ-028 SHALL, without BTN_EVT_RELEASE_EN, generate no release strobes and queue press events only; btn_state still tracks both levels and the evt_data MSB is always 1.

Structure
REQ-029 SHALL place the EVT_W function ($clog2(N_BTN)+1), the edge encoding constants EDGE_PRESS=1 and EDGE_RELEASE=0, and the event field offsets in shared package btn_evt_pkg.
REQ-030 SHALL implement the synchroniser, counter and edge strobe of one channel in sub-module btn_debounce, instantiated N_BTN times; the arbiter and FIFO stay in btn_event_unit.

Verification (N_BTN=4, DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-031 SHALL cover: btn[2] rises and is held -> btn_state[2]=1 and evt_valid=1 with evt_data=3'b110 at cycle 8 after the edge; evt_pop -> evt_count=0.
REQ-032 SHALL cover: btn[1] high for 3 cycles, then low -> no btn_state change and evt_count stays 0.
REQ-033 SHALL cover: btn[0] and btn[3] rise in the same cycle -> events 3'b100 then 3'b111 on consecutive cycles, evt_count=2.
REQ-034 SHALL cover: 5 presses without popping -> evt_count=4 and ovf=1 once the fifth event stalls behind a sixth strobe; evt_pop together with a push at full -> evt_count stays 4; ovf_clr -> ovf=0.
REQ-035 SHALL cover: press then release of btn[1] -> events 3'b101 then 3'b001 with BTN_EVT_RELEASE_EN, and only 3'b101 without it.
REQ-036 SHALL cover: reset=0 for 1 cycle with 3 queued events and a debounce half complete -> all outputs 0 immediately; a held button re-reports after 8 cycles.
